pwm_multi_channel: RTL

Parametrised multi-channel PWM generator: the successor to the single-prescaler, fixed-channel PWM block. One shared prescaler and one period counter drive CHANNELS independent outputs. Each output has its own duty value, written over a simple write port and double-buffered so that it only takes effect at a period boundary, which gives glitch-free updates. Sits between the user-input decode logic and the output pins of the top level.

---
 rtl/pwm_multi_channel.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel
//
// Multi-channel PWM generator. A shared prescaler produces a step tick every
// prescale+1 clocks. A shared period counter counts 0..period on those ticks.
// Each channel compares the period counter against its own active duty value.
// Duty values are double-buffered:
//   - a write lands in a pending register;
//   - the pending value is copied to the active register only at a period
//     wrap, or continuously while the block is disabled.
// This keeps every update glitch-free. The period value is shadowed the same
// way, so a period change takes effect at the next boundary.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       1 = counters run; 0 = counters held at 0, outputs idle
//   prescale     step tick every prescale+1 clk cycles
//   period       period counter counts 0..period
//   wr_en        duty write strobe
//   wr_ch        target channel of the write (>= CHANNELS is ignored)
//   wr_duty      duty value: high steps per period
//   invert       per-channel output polarity (XOR)
//   pwm_out      registered PWM outputs
//   period_tick  one-cycle pulse, registered from the period wrap
// ---------------------------------------------------------------------------
module pwm_multi_channel #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int PRESC_W  = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic [CNT_W-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_duty,
    input  logic [CHANNELS-1:0] invert,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    // One extra bit so that CHANNELS itself is representable (e.g. 16 with CH_W=4).
    localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);

    logic [PRESC_W-1:0]  presc_cnt;
    logic [CNT_W-1:0]    step_cnt;
    logic [CNT_W-1:0]    period_act;
    logic [CNT_W-1:0]    pend [CHANNELS];
    logic [CNT_W-1:0]    act  [CHANNELS];

    logic                tick;
    logic                wrap;
    logic                shadow_load;
    logic                wr_valid;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] raw_p0;

    // Stage 0: step tick, period wrap and write decode (combinational)
    // Using >= makes a lowered prescale force a tick on the next cycle
    // instead of letting the counter run all the way around.
    assign tick        = enable && (presc_cnt >= prescale);
    assign wrap        = tick && (step_cnt >= period_act);
    assign shadow_load = !enable || wrap;
    assign wr_valid    = wr_en && ({1'b0, wr_ch} < CH_LIMIT);

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = wr_valid && (wr_ch == CH_W'(i));
        end
    end

    always_comb begin
        raw_p0 = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw_p0[i] = enable && (step_cnt < act[i]);
        end
    end

    // Stage 1: counters, shadow registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            step_cnt  <= '0;
        end else if (!enable) begin
            presc_cnt <= '0;
            step_cnt  <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            step_cnt  <= wrap ? '0 : step_cnt + CNT_W'(1);
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act <= '0;
        end else if (shadow_load) begin
            period_act <= period;
        end
    end

    // A write that coincides with a shadow load bypasses the pending
    // register, so the new duty is used by the period starting now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit[i]) begin
                    pend[i] <= wr_duty;
                end
                if (shadow_load) begin
                    act[i] <= wr_hit[i] ? wr_duty : pend[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= raw_p0 ^ invert;
            period_tick <= wrap;
        end
    end

endmodule
